mlp_train_sequencer: RTL and testbench

- Dataset and epoch controller that sits directly upstream of MLP.
- Stores a small real-valued training set and drives MLP values/expected/training one sample per cycle.
- Runs EPOCHS iterations of one training pass followed by one evaluation pass.
- During evaluation it scores the returned prediction: per-epoch classification count and binary cross-entropy cost. Replaces hand-written stimulus loops in benches and system top.

---
 rtl/mlp_train_sequencer_pkg.sv | 16 +
 rtl/mlp_train_sequencer_score_unit.sv | 25 ++
 rtl/mlp_train_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_mlp_train_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_train_sequencer_pkg.sv
// Shared types and constants for the MLP training/evaluation sequencer.
// The dataset sample struct lives in the top because its array sizes follow the instance parameters.
package mlp_train_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAIN,
    ST_EVAL,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // Keeps ln() finite when a prediction saturates at exactly 0.0 or 1.0.
  localparam real BCE_EPS = 1.0e-12;

endpackage

// File: rtl/mlp_train_sequencer_score_unit.sv
// Scores one returned prediction against its delayed target: threshold-match
// classification plus binary cross-entropy summed over all outputs.
module mlp_train_sequencer_score_unit
  import mlp_train_sequencer_pkg::*;
#(
  parameter int OUTPUTS = 1
) (
  input  real  pred  [OUTPUTS],
  input  real  exp_v [OUTPUTS],
  input  real  thr,
  output logic correct,
  output real  cost
);

  always_comb begin
    correct = 1'b1;
    cost    = 0.0;
    for (int o = 0; o < OUTPUTS; o++) begin
      if ((pred[o] < thr) != (exp_v[o] < thr)) correct = 1'b0;
      cost = cost - (exp_v[o] * $ln(pred[o] + BCE_EPS)
                     + (1.0 - exp_v[o]) * $ln(1.0 - pred[o] + BCE_EPS));
    end
  end

endmodule

// File: rtl/mlp_train_sequencer.sv
// Dataset store and epoch controller feeding an MLP: per epoch one training pass,
// one scored evaluation pass and a drain that waits out the prediction latency.
module mlp_train_sequencer
  import mlp_train_sequencer_pkg::*;
#(
  parameter int INPUTS       = 2,
  parameter int OUTPUTS      = 1,
  parameter int DEPTH        = 4,
  parameter int EPOCHS       = 100,
  parameter int PRED_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  real                      wr_values    [INPUTS],
  input  real                      wr_expected  [OUTPUTS],
  input  logic [$clog2(DEPTH):0]   sample_count,
  input  real                      threshold,
  input  logic                     start,
  input  logic                     abort,
  output real                      values       [INPUTS],
  output real                      expected     [OUTPUTS],
  output logic                     training,
  input  real                      prediction   [OUTPUTS],
  output logic                     busy,
  output logic [31:0]              epoch,
  output logic                     epoch_done,
  output logic [31:0]              eval_correct,
  output real                      epoch_cost,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(PRED_LATENCY + 1);

  typedef struct {
    real values   [INPUTS];
    real expected [OUTPUTS];
  } dataset_sample_t;

  dataset_sample_t mem_q [DEPTH];
  dataset_sample_t wr_sample;

  seq_state_e  state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW:0]   n_q, n_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [31:0] epoch_q, epoch_d, eval_correct_q, eval_correct_d, acc_correct_q, acc_correct_d;
  real         thr_q, thr_d, epoch_cost_q, epoch_cost_d, acc_cost_q, acc_cost_d;
  logic        busy_q, busy_d, done_q, done_d, training_q, training_d, epoch_done_q, epoch_done_d;
  real         values_q   [INPUTS],  values_d   [INPUTS];
  real         expected_q [OUTPUTS], expected_d [OUTPUTS];
  logic [PRED_LATENCY-1:0] dl_vld_q, dl_vld_d;
  real         dl_exp_q [PRED_LATENCY][OUTPUTS], dl_exp_d [PRED_LATENCY][OUTPUTS];
  real         sc_exp [OUTPUTS];
  real         sc_cost;
  logic        sc_correct, sc_vld, last, load, wr_ok;

  assign wr_ok  = wr_en && !busy_q && (int'(wr_addr) < DEPTH);
  assign last   = ({1'b0, k_q} == n_q - 1'b1);
  assign sc_vld = dl_vld_q[PRED_LATENCY-1];

  always_comb begin
    for (int i = 0; i < INPUTS; i++)  wr_sample.values[i]   = wr_values[i];
    for (int o = 0; o < OUTPUTS; o++) wr_sample.expected[o] = wr_expected[o];
  end

  // Dataset memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_addr] <= wr_sample;
  end

  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) sc_exp[o] = dl_exp_q[PRED_LATENCY-1][o];
  end

  mlp_train_sequencer_score_unit #(.OUTPUTS(OUTPUTS)) u_score (
    .pred    (prediction),
    .exp_v   (sc_exp),
    .thr     (thr_q),
    .correct (sc_correct),
    .cost    (sc_cost)
  );

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    n_d            = n_q;
    thr_d          = thr_q;
    epoch_d        = epoch_q;
    drain_d        = drain_q;
    done_d         = done_q;
    epoch_done_d   = 1'b0;
    eval_correct_d = eval_correct_q;
    epoch_cost_d   = epoch_cost_q;
    acc_correct_d  = acc_correct_q;
    acc_cost_d     = acc_cost_q;
    load           = 1'b0;
    if (sc_vld) begin
      acc_correct_d = acc_correct_q + 32'(sc_correct);
      acc_cost_d    = acc_cost_q + sc_cost;
    end
    if (abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start && sample_count != '0 && int'(sample_count) <= DEPTH) begin
          n_d     = sample_count;
          thr_d   = threshold;
          done_d  = 1'b0;
          epoch_d = '0;
          k_d     = '0;
          load    = 1'b1;
          state_d = ST_TRAIN;
        end
        ST_TRAIN: begin
          load = 1'b1;
          if (last) begin
            k_d           = '0;
            acc_correct_d = '0;
            acc_cost_d    = 0.0;
            state_d       = ST_EVAL;
          end else k_d = k_q + 1'b1;
        end
        ST_EVAL: begin
          if (last) begin
            drain_d = '0;
            state_d = ST_DRAIN;
          end else begin
            k_d  = k_q + 1'b1;
            load = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == DW'(PRED_LATENCY - 1)) begin
            // Publish includes the final sample being scored this cycle.
            eval_correct_d = acc_correct_d;
            epoch_cost_d   = acc_cost_d;
            epoch_done_d   = 1'b1;
            if (epoch_q == 32'(EPOCHS - 1)) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              epoch_d = epoch_q + 32'd1;
              k_d     = '0;
              load    = 1'b1;
              state_d = ST_TRAIN;
            end
          end else drain_d = drain_q + 1'b1;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    training_d = (state_d == ST_TRAIN);
    busy_d     = (state_d == ST_TRAIN) || (state_d == ST_EVAL) || (state_d == ST_DRAIN);
    for (int i = 0; i < INPUTS; i++)
      values_d[i] = load ? mem_q[k_d].values[i] : values_q[i];
    for (int o = 0; o < OUTPUTS; o++)
      expected_d[o] = load ? mem_q[k_d].expected[o] : expected_q[o];
    // Delay line carries each eval target forward to meet its prediction.
    for (int s = PRED_LATENCY - 1; s > 0; s--) begin
      dl_vld_d[s] = dl_vld_q[s-1];
      for (int o = 0; o < OUTPUTS; o++) dl_exp_d[s][o] = dl_exp_q[s-1][o];
    end
    dl_vld_d[0] = (state_q == ST_EVAL) && !abort;
    for (int o = 0; o < OUTPUTS; o++) dl_exp_d[0][o] = expected_q[o];
    if (abort) dl_vld_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      k_q            <= '0;
      n_q            <= '0;
      drain_q        <= '0;
      thr_q          <= 0.0;
      epoch_q        <= '0;
      eval_correct_q <= '0;
      epoch_cost_q   <= 0.0;
      acc_correct_q  <= '0;
      acc_cost_q     <= 0.0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      training_q     <= 1'b0;
      epoch_done_q   <= 1'b0;
      dl_vld_q       <= '0;
      for (int i = 0; i < INPUTS; i++) values_q[i] <= 0.0;
      for (int o = 0; o < OUTPUTS; o++) expected_q[o] <= 0.0;
      for (int s = 0; s < PRED_LATENCY; s++)
        for (int o = 0; o < OUTPUTS; o++) dl_exp_q[s][o] <= 0.0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      n_q            <= n_d;
      drain_q        <= drain_d;
      thr_q          <= thr_d;
      epoch_q        <= epoch_d;
      eval_correct_q <= eval_correct_d;
      epoch_cost_q   <= epoch_cost_d;
      acc_correct_q  <= acc_correct_d;
      acc_cost_q     <= acc_cost_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      training_q     <= training_d;
      epoch_done_q   <= epoch_done_d;
      dl_vld_q       <= dl_vld_d;
      for (int i = 0; i < INPUTS; i++) values_q[i] <= values_d[i];
      for (int o = 0; o < OUTPUTS; o++) expected_q[o] <= expected_d[o];
      for (int s = 0; s < PRED_LATENCY; s++)
        for (int o = 0; o < OUTPUTS; o++) dl_exp_q[s][o] <= dl_exp_d[s][o];
    end
  end

  always_comb begin
    for (int i = 0; i < INPUTS; i++) values[i] = values_q[i];
    for (int o = 0; o < OUTPUTS; o++) expected[o] = expected_q[o];
  end

  assign training     = training_q;
  assign busy         = busy_q;
  assign epoch        = epoch_q;
  assign epoch_done   = epoch_done_q;
  assign eval_correct = eval_correct_q;
  assign epoch_cost   = epoch_cost_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Scoreboard bench: XOR dataset, stub MLPs with latency 1 and 3, constant-prediction
// cost cases, abort, mid-run reset, rejected starts and writes while busy.
module tb_mlp_train_sequencer;

  localparam real LN2 = 0.6931471805599453;
  localparam real C25 = 3.3479528671433;  // 2*(-ln 0.75 - ln 0.25)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  real        wr_values [2];
  real        wr_expected [1];
  logic [2:0] sample_count = 3'd4;
  real        threshold = 0.5;
  logic       start = 1'b0, abort = 1'b0, start3 = 1'b0, abort3 = 1'b0;

  real         values [2], expected [1], pred [1];
  logic        training, busy, epoch_done, done;
  logic [31:0] epoch, eval_correct;
  real         epoch_cost;

  real         values3 [2], expected3 [1], pred3 [1];
  logic        training3, busy3, epoch_done3, done3;
  logic [31:0] epoch3, eval_correct3;
  real         epoch_cost3;

  mlp_train_sequencer #(.INPUTS(2), .OUTPUTS(1), .DEPTH(4), .EPOCHS(2), .PRED_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_values(wr_values),
    .wr_expected(wr_expected), .sample_count(sample_count), .threshold(threshold),
    .start(start), .abort(abort), .values(values), .expected(expected), .training(training),
    .prediction(pred), .busy(busy), .epoch(epoch), .epoch_done(epoch_done),
    .eval_correct(eval_correct), .epoch_cost(epoch_cost), .done(done)
  );

  mlp_train_sequencer #(.INPUTS(2), .OUTPUTS(1), .DEPTH(4), .EPOCHS(1), .PRED_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_values(wr_values),
    .wr_expected(wr_expected), .sample_count(sample_count), .threshold(threshold),
    .start(start3), .abort(abort3), .values(values3), .expected(expected3), .training(training3),
    .prediction(pred3), .busy(busy3), .epoch(epoch3), .epoch_done(epoch_done3),
    .eval_correct(eval_correct3), .epoch_cost(epoch_cost3), .done(done3)
  );

  // Stub MLPs: mode 0 echoes the target after the latency, 1/2 give constants.
  int  mode = 0;
  real p1 = 0.0, p3a = 0.0, p3b = 0.0, p3c = 0.0;
  always @(posedge clk) begin
    p1  <= expected[0];
    p3a <= expected3[0];
    p3b <= p3a;
    p3c <= p3b;
  end
  always_comb begin
    case (mode)
      0:       pred[0] = p1;
      1:       pred[0] = 0.5;
      default: pred[0] = 0.25;
    endcase
    pred3[0] = p3c;
  end

  typedef struct { int ep; int corr; real cost; int off; } exp_t;
  exp_t q1 [$];
  exp_t q3 [$];
  exp_t e1, e3;
  int checks = 0, errors = 0;
  int cyc = 0, st1 = 0, st3 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_int(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_real(input string nm, input real act, input real req);
    checks++;
    if ((act - req > 1.0e-6) || (req - act > 1.0e-6)) begin
      errors++;
      $display("FAIL %s: got %f, expected %f", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input int ep, input int corr, input real cost, input int off);
    exp_t r;
    r.ep = ep; r.corr = corr; r.cost = cost; r.off = off;
    return r;
  endfunction

  // Monitor: each epoch_done pops the next expected result.
  always @(negedge clk) begin
    if (rst_n && epoch_done) begin
      if (q1.size() == 0) chk_int("dut spurious epoch_done", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk_int("dut epoch", epoch, e1.ep);
        chk_int("dut eval_correct", eval_correct, e1.corr);
        chk_real("dut epoch_cost", epoch_cost, e1.cost);
        chk_int("dut epoch_done cycle", cyc - st1, e1.off);
      end
    end
    if (rst_n && epoch_done3) begin
      if (q3.size() == 0) chk_int("dut3 spurious epoch_done", 1, 0);
      else begin
        e3 = q3.pop_front();
        chk_int("dut3 epoch", epoch3, e3.ep);
        chk_int("dut3 eval_correct", eval_correct3, e3.corr);
        chk_real("dut3 epoch_cost", epoch_cost3, e3.cost);
        chk_int("dut3 epoch_done cycle", cyc - st3, e3.off);
      end
    end
  end

  task automatic write(input int a, input real v0, input real v1, input real e);
    wr_en = 1'b1; wr_addr = a[1:0];
    wr_values[0] = v0; wr_values[1] = v1; wr_expected[0] = e;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic go1(input int n);
    sample_count = n[2:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0; st1 = cyc;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 300) begin @(negedge clk); n++; end
    chk_int({nm, " done"}, done, 1);
    chk_int({nm, " busy at done"}, busy, 0);
    @(negedge clk);
    chk_int({nm, " done held in idle"}, done, 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [8:0]  tr_bits, ex_bits, v0_bits;
  logic [10:0] tr3_bits;

  initial begin
    wr_values[0] = 0.0; wr_values[1] = 0.0; wr_expected[0] = 0.0;
    repeat (2) @(negedge clk);
    chk_real("reset values[0]", values[0], 0.0);
    chk_real("reset expected[0]", expected[0], 0.0);
    chk_int("reset training", training, 0);
    chk_int("reset busy", busy, 0);
    chk_int("reset epoch", epoch, 0);
    chk_int("reset epoch_done", epoch_done, 0);
    chk_int("reset eval_correct", eval_correct, 0);
    chk_real("reset epoch_cost", epoch_cost, 0.0);
    chk_int("reset done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    write(0, 0.0, 0.0, 0.0);
    write(1, 0.0, 1.0, 1.0);
    write(2, 1.0, 0.0, 1.0);
    write(3, 1.0, 1.0, 0.0);

    // Echo stub, two epochs of XOR.
    mode = 0; threshold = 0.5;
    q1.push_back(mk(1, 4, 0.0, 9));
    q1.push_back(mk(1, 4, 0.0, 18));
    go1(4);
    chk_int("run1 busy after start", busy, 1);
    chk_int("run1 epoch at start", epoch, 0);
    for (int i = 0; i < 9; i++) begin
      tr_bits[i] = training; ex_bits[i] = expected[0] > 0.5; v0_bits[i] = values[0] > 0.5;
      if (i < 8) @(negedge clk);
    end
    chk_int("run1 training pattern", tr_bits, 9'b000001111);
    chk_int("run1 expected sequence", ex_bits, 9'b001100110);
    chk_int("run1 values[0] sequence", v0_bits, 9'b111001100);
    wait_done("run1");
    chk_int("run1 final epoch", epoch, 1);

    // Latency-3 instance: drain must last exactly 3 cycles.
    q3.push_back(mk(0, 4, 0.0, 11));
    sample_count = 3'd4; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0; st3 = cyc;
    for (int i = 0; i < 11; i++) begin
      tr3_bits[i] = training3;
      if (i < 10) @(negedge clk);
    end
    chk_int("lat3 training pattern", tr3_bits, 11'b00000001111);
    for (int n = 0; n < 50 && !done3; n++) @(negedge clk);
    chk_int("lat3 done", done3, 1);
    @(negedge clk);

    // Constant 0.5 prediction at threshold 0.5.
    mode = 1;
    q1.push_back(mk(1, 2, 4.0 * LN2, 9));
    q1.push_back(mk(1, 2, 4.0 * LN2, 18));
    go1(4);
    chk_int("run2 done cleared by start", done, 0);
    wait_done("run2");

    // Constant 0.25 with writes attempted while busy; rerun must match.
    mode = 2;
    q1.push_back(mk(1, 2, C25, 9));
    q1.push_back(mk(1, 2, C25, 18));
    go1(4);
    wr_en = 1'b1; wr_addr = 2'd0;
    wr_values[0] = 1.0; wr_values[1] = 1.0; wr_expected[0] = 1.0;
    repeat (6) @(negedge clk);
    wr_en = 1'b0;
    wait_done("busy-write run");
    q1.push_back(mk(1, 2, C25, 9));
    q1.push_back(mk(1, 2, C25, 18));
    go1(4);
    wait_done("busy-write rerun");

    // Abort on the second TRAIN cycle of epoch 1.
    mode = 0;
    q1.push_back(mk(1, 4, 0.0, 9));
    go1(4);
    repeat (10) @(negedge clk);
    chk_int("pre-abort training", training, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_int("abort busy", busy, 0);
    chk_int("abort training", training, 0);
    chk_int("abort done", done, 0);
    chk_int("abort epoch retained", epoch, 1);
    chk_int("abort eval_correct retained", eval_correct, 4);
    repeat (3) @(negedge clk);
    chk_int("abort stays idle", busy, 0);
    q1.push_back(mk(1, 4, 0.0, 9));
    q1.push_back(mk(1, 4, 0.0, 18));
    go1(4);
    chk_int("restart epoch", epoch, 0);
    chk_real("restart sample0 values[1]", values[1], 0.0);
    @(negedge clk);
    chk_real("restart sample1 values[1]", values[1], 1.0);
    wait_done("restart");

    // Start and abort together, then out-of-range counts.
    sample_count = 3'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk_int("start+abort busy", busy, 0);
    chk_int("start+abort clears done", done, 0);
    go1(0);
    chk_int("count 0 busy", busy, 0);
    go1(5);
    chk_int("count 5 busy", busy, 0);

    // Asynchronous reset in the middle of EVAL.
    q1.push_back(mk(1, 4, 0.0, 9));
    q1.push_back(mk(1, 4, 0.0, 18));
    go1(4);
    repeat (5) @(negedge clk);
    chk_real("pre-reset expected", expected[0], 1.0);
    q1.delete();
    rst_n = 1'b0;
    #1;
    chk_int("async reset busy", busy, 0);
    chk_int("async reset training", training, 0);
    chk_real("async reset values[1]", values[1], 0.0);
    chk_real("async reset expected", expected[0], 0.0);
    chk_int("async reset eval_correct", eval_correct, 0);
    chk_real("async reset epoch_cost", epoch_cost, 0.0);
    chk_int("async reset epoch", epoch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q1.push_back(mk(1, 4, 0.0, 9));
    q1.push_back(mk(1, 4, 0.0, 18));
    go1(4);
    wait_done("post-reset run");

    chk_int("dut scoreboard drained", q1.size(), 0);
    chk_int("dut3 scoreboard drained", q3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
